// File: rtl/sm_dbg_pkg.sv
// Shared encodings for the debug-register dump path: FSM states and record layout.
package sm_dbg_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_NEXT   = 2'd3;

    // Index byte, then the register value MSB first.
    localparam int         RECORD_BYTES = 5;
    localparam logic [2:0] IDX_BYTE_PAD = 3'b000;

    function automatic logic [7:0] index_byte(input logic [4:0] addr);
        return {IDX_BYTE_PAD, addr};
    endfunction

endpackage

// File: rtl/sm_dump_serializer.sv
// Holds one captured register value and shifts it out as a 5-byte valid/ready record.
module sm_dump_serializer
    import sm_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [4:0]  index,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_accepted
);

    localparam logic [2:0] LAST_IDX = 3'(RECORD_BYTES - 1);

    logic [31:0] hold;
    logic [2:0]  byte_idx;
    logic        accept;

    assign accept        = tx_valid && tx_ready;
    assign last_accepted = accept && (byte_idx == LAST_IDX);

    // tx_data only moves on load or handshake, so it is stable across any stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= 32'd0;
            byte_idx <= 3'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
        end else if (load) begin
            hold     <= word;
            byte_idx <= 3'd0;
            tx_data  <= index_byte(index);
            tx_valid <= 1'b1;
        end else if (accept) begin
            if (byte_idx == LAST_IDX) begin
                tx_valid <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 3'd1;
                case (byte_idx)
                    3'd0:    tx_data <= hold[31:24];
                    3'd1:    tx_data <= hold[23:16];
                    3'd2:    tx_data <= hold[15:8];
                    default: tx_data <= hold[7:0];
                endcase
            end
        end
    end

endmodule

// File: rtl/sm_reg_dumper.sv
// Walks regAddr over FIRST_REG..LAST_REG, waits SETTLE cycles per address, and
// streams each captured register out as a byte record.
//   state  | meaning
//   IDLE   | waiting for start
//   SETTLE | address presented, counting down before sampling regData
//   SEND   | serializer shifting out the current record
//   NEXT   | record finished; advance address or end/restart the dump
module sm_reg_dumper
    import sm_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int SETTLE    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        loop,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_ADDR  = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR   = 5'(LAST_REG);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_t     state;
    logic [7:0] settle_cnt;
    logic       capture;
    logic       last_accepted;

    assign capture = (state == ST_SETTLE) && (settle_cnt == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            regAddr    <= FIRST_ADDR;
            settle_cnt <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start coincident with the done pulse belongs to the finished dump.
                    if (start && !done) begin
                        busy       <= 1'b1;
                        regAddr    <= FIRST_ADDR;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= ST_SEND;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                ST_SEND: begin
                    if (last_accepted) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Compare before incrementing so LAST_REG=31 never wraps.
                    if (regAddr != LAST_ADDR) begin
                        regAddr    <= regAddr + 5'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end else begin
                        done    <= 1'b1;
                        regAddr <= FIRST_ADDR;
                        if (loop) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_SETTLE;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sm_dump_serializer u_serializer (
        .clk           (clk),
        .rst           (rst),
        .load          (capture),
        .word          (regData),
        .index         (regAddr),
        .tx_ready      (txReady),
        .tx_data       (txData),
        .tx_valid      (txValid),
        .last_accepted (last_accepted)
    );

endmodule

// File: tb/tb_sm_reg_dumper.sv
// Scoreboard bench: two dumper instances (short range, and a range ending at 31 with loop).
module tb_sm_reg_dumper;

    localparam int FIRST_A  = 0;
    localparam int LAST_A   = 2;
    localparam int SETTLE_A = 4;
    localparam int FIRST_B  = 30;
    localparam int LAST_B   = 31;
    localparam int SETTLE_B = 2;
    localparam int MARK     = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, loop_a, ready_a, txv_a, busy_a, done_a;
    logic [4:0]  addr_a;
    logic [31:0] data_a;
    logic [7:0]  txd_a;
    logic        rst_b, start_b, loop_b, ready_b, txv_b, busy_b, done_b;
    logic [4:0]  addr_b;
    logic [31:0] data_b;
    logic [7:0]  txd_b;

    sm_reg_dumper #(.FIRST_REG(FIRST_A), .LAST_REG(LAST_A), .SETTLE(SETTLE_A)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .loop(loop_a), .regAddr(addr_a),
        .regData(data_a), .txData(txd_a), .txValid(txv_a), .txReady(ready_a),
        .busy(busy_a), .done(done_a));

    sm_reg_dumper #(.FIRST_REG(FIRST_B), .LAST_REG(LAST_B), .SETTLE(SETTLE_B)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .loop(loop_b), .regAddr(addr_b),
        .regData(data_b), .txData(txd_b), .txValid(txv_b), .txReady(ready_b),
        .busy(busy_b), .done(done_b));

    // Debug port model: register bank behind an address path of SETTLE-1 stages,
    // so data is only correct from exactly SETTLE cycles after regAddr moves.
    // While a record is being sent, port A returns garbage.
    logic [31:0] bank [2][32];
    logic [4:0]  pa0, pa1, pa2, pb0;
    always @(posedge clk) begin
        pa0 <= addr_a;
        pa1 <= pa0;
        pa2 <= pa1;
        pb0 <= addr_b;
    end
    assign data_a = txv_a ? 32'hDEAD_BEEF : bank[0][pa2];
    assign data_b = bank[1][pb0];

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];
    int ready_mode[2] = '{0, 0};
    int hold_low[2]   = '{0, 0};

    task automatic check(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qpop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qpush(input int k, input int v);
        if (k == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    // Expected stream for one whole dump, followed by a done marker carrying busy and regAddr.
    task automatic push_dump(input int k, input int first, input int last, input int busy_after);
        for (int r = first; r <= last; r++) begin
            qpush(k, r);
            for (int b = 3; b >= 0; b--) qpush(k, int'((bank[k][r] >> (8 * b)) & 32'hFF));
        end
        qpush(k, MARK + busy_after * 32 + first);
    endtask

    initial begin
        ready_a = 1'b1;
        ready_b = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low[0] > 0) begin
                ready_a = 1'b0;
                hold_low[0]--;
            end else begin
                ready_a = (ready_mode[0] != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            ready_b = (ready_mode[1] != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic       pv[2], pr[2], pdn[2];
    logic [7:0] pd[2];

    task automatic mon(input int k, input logic r, input logic v, input logic rd, input logic dn,
                       input logic bz, input logic [7:0] d, input logic [4:0] a);
        int e;
        if (r) begin
            pv[k]  = 1'b0;
            pr[k]  = 1'b0;
            pdn[k] = 1'b0;
        end else begin
            if (pv[k] && !pr[k]) begin
                check("stall_valid", k, int'(v), 1);
                check("stall_data", k, int'(d), int'(pd[k]));
            end
            if (v && rd) begin
                check("byte_expected", k, int'(qsize(k) > 0), 1);
                if (qsize(k) > 0) begin
                    e = qpop(k);
                    check("tx_byte", k, int'(d), e);
                end
            end
            if (dn) begin
                check("done_single", k, int'(pdn[k]), 0);
                check("done_expected", k, int'(qsize(k) > 0), 1);
                if (qsize(k) > 0) begin
                    e = qpop(k);
                    check("done_state", k, MARK + int'(bz) * 32 + int'(a), e);
                end
            end
            if (k == 1) check("addr_range", k, int'(a >= 5'd30), 1);
            pv[k]  = v;
            pr[k]  = rd;
            pd[k]  = d;
            pdn[k] = dn;
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst_a, txv_a, ready_a, done_a, busy_a, txd_a, addr_a);
        mon(1, rst_b, txv_b, ready_b, done_b, busy_b, txd_b, addr_b);
    end

    task automatic pulse_start(input int k);
        @(posedge clk);
        #1;
        if (k == 0) start_a = 1'b1;
        else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        bit ok = 1'b0;
        while (n < budget && !ok) begin
            @(posedge clk);
            #2;
            n++;
            ok = (qsize(k) == 0) && !((k == 0) ? busy_a : busy_b);
        end
        check("idle_reached", k, int'(ok), 1);
    endtask

    task automatic wait_qsize(input int k, input int target, input int budget);
        int n = 0;
        while (n < budget && qsize(k) > target) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("queue_progress", k, int'(qsize(k) <= target), 1);
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (n < budget && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = (k == 0) ? done_a : done_b;
        end
        check("done_seen", k, int'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        loop_a = 1'b0; loop_b = 1'b0;
        for (int r = 0; r < 32; r++) begin
            bank[0][r] = 32'h1122_3300 | 32'(r);
            bank[1][r] = $urandom;
        end
        repeat (5) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_addr", 0, int'(addr_a), FIRST_A);
        check("rst_valid", 0, int'(txv_a), 0);
        check("rst_data", 0, int'(txd_a), 0);
        check("rst_busy", 0, int'(busy_a), 0);
        check("rst_done", 0, int'(done_a), 0);
        check("rst_addr", 1, int'(addr_b), FIRST_B);

        // Basic dump, sink always ready; regData is garbage whenever a record is in flight.
        push_dump(0, FIRST_A, LAST_A, 0);
        pulse_start(0);
        wait_idle(0, 400);

        // Random backpressure with a forced 10-cycle stall inside the first record.
        ready_mode[0] = 1;
        push_dump(0, FIRST_A, LAST_A, 0);
        pulse_start(0);
        wait_qsize(0, 13, 200);
        hold_low[0] = 10;
        wait_idle(0, 1000);

        // Random register contents under random backpressure.
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < 32; r++) bank[0][r] = $urandom;
            push_dump(0, FIRST_A, LAST_A, 0);
            pulse_start(0);
            wait_idle(0, 1000);
        end

        // start during SEND and in the done cycle are both ignored.
        ready_mode[0] = 0;
        push_dump(0, FIRST_A, LAST_A, 0);
        pulse_start(0);
        begin
            int n = 0;
            while (n < 100 && !txv_a) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("send_reached", 0, int'(txv_a), 1);
        end
        pulse_start(0);
        wait_done(0, 400);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("busy_after_done", 0, int'(busy_a), 0);
        repeat (20) @(posedge clk);
        #1;
        check("still_idle_busy", 0, int'(busy_a), 0);
        check("still_idle_valid", 0, int'(txv_a), 0);
        check("queue_drained", 0, qsize(0), 0);
        push_dump(0, FIRST_A, LAST_A, 0);
        pulse_start(0);
        wait_idle(0, 400);

        // Reset while byte 2 of the second record is presented, then a clean dump.
        push_dump(0, FIRST_A, LAST_A, 0);
        pulse_start(0);
        wait_qsize(0, 9, 200);
        rst_a = 1'b1;
        #1;
        check("abort_valid", 0, int'(txv_a), 0);
        check("abort_busy", 0, int'(busy_a), 0);
        check("abort_addr", 0, int'(addr_a), FIRST_A);
        q0.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        push_dump(0, FIRST_A, LAST_A, 0);
        pulse_start(0);
        wait_idle(0, 400);

        // Range ending at 31 with loop: second dump starts on its own, then stops.
        ready_mode[1] = 1;
        loop_b = 1'b1;
        push_dump(1, FIRST_B, LAST_B, 1);
        push_dump(1, FIRST_B, LAST_B, 0);
        pulse_start(1);
        wait_done(1, 400);
        loop_b = 1'b0;
        wait_idle(1, 600);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_reg_dumper.md
Name: sm_reg_dumper

Overview:
- Consumer end of the core's debug register port (regAddr out, regData in).
- Steps regAddr through a register range and waits for the debug path to settle. Captures each 32-bit value and streams it out as bytes over a valid/ready interface, e.g. to a UART transmitter or an LED scanner.
- Sits at board level beside the input debouncers, on the board clock.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31)
- LAST_REG, 31, last register index dumped (FIRST_REG..31)
- SETTLE, 4, cycles to wait after regAddr changes before sampling regData (covers 2-stage debouncer plus core read path); legal range 1..255

Ports:
- clk  input  1  board clock; all state on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a dump; ignored while busy
- loop  input  1  sampled at end of dump; if high, the next dump starts automatically
- regAddr  output  5  register index presented to the debug port
- regData  input  32  register value returned by the debug port
- txData  output  8  stream byte
- txValid  output  1  txData valid
- txReady  input  1  sink accepts byte when txValid && txReady
- busy  output  1  high from start acceptance until the dump completes
- done  output  1  one-cycle pulse after the final byte of a dump is accepted

Behaviour:
- Reset (async, active-high):
  - state IDLE, regAddr=FIRST_REG, txData=0, txValid=0, busy=0, done=0.
  - Settle counter 0, capture register 0.
- Record format, per register (5 bytes): index byte {3'b000, regAddr}, then regData[31:24], [23:16], [15:8], [7:0].
- FSM states: IDLE, SETTLE, SEND, NEXT.
- IDLE:
  - start=1 at cycle t: at t+1, busy=1, regAddr=FIRST_REG, counter=SETTLE-1, state SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0: capture regData into a 32-bit holding register, load byte index 0, and go to SEND.
  - txValid rises the cycle after capture.
  - Sampling therefore occurs exactly SETTLE cycles after regAddr changed.
- SEND:
  - txValid=1; txData holds the current byte and stays stable while txReady=0 (stall of any length).
  - On handshake, the next byte is presented the following cycle with txValid still high (no bubble inside a record).
  - Captured value is held; regData changes during SEND have no effect.
  - After the 5th byte is accepted: txValid=0 next cycle, state NEXT.
- NEXT:
  - If regAddr != LAST_REG: regAddr+1, counter=SETTLE-1, state SETTLE.
  - If regAddr == LAST_REG: done=1 for one cycle and regAddr=FIRST_REG.
    - loop=1: stay busy, state SETTLE (new dump).
    - loop=0: busy=0, state IDLE.
  - The compare happens before the increment, so LAST_REG=31 never wraps the 5-bit address.
- Simultaneous events:
  - start while busy: ignored.
  - start in the same cycle as done with loop=0: ignored; the first start accepted is the one in IDLE.
- Reset mid-operation: the stream aborts immediately and txValid drops without completing the record; the sink must tolerate a truncated record.
- Any txValid/txData change other than via handshake or reset is a bug; the bench asserts this.
- Widths: settle counter 8 bits; byte index 3 bits (0..4); no arithmetic wider than 5 bits on the address.

Decomposition:
- Shared package sm_dbg_pkg holds:
  - FSM state encoding (IDLE, SETTLE, SEND, NEXT).
  - RECORD_BYTES=5.
  - The index-byte format constant.
- One natural sub-module: sm_dump_serializer. It takes a 32-bit word plus index, performs the 5-byte valid/ready shift-out, and returns a last-byte-accepted pulse. The top FSM handles addressing and settling.

Test Plan:
- FIRST_REG=0, LAST_REG=2, SETTLE=4, regData=0x11223300|addr, txReady=1, start pulse -> stream 00 11 22 33 00, 01 11 22 33 01, 02 11 22 33 02. regAddr 0,1,2 each held ≥4 cycles before sample. done pulses once; busy then 0.
- Same config, txReady toggled randomly, held low 10 cycles mid-record -> byte sequence identical, txData stable during each stall, no byte duplicated or dropped.
- regData changed to 0xDEADBEEF one cycle after capture of reg 1 -> reg 1 record still 01 11 22 33 01.
- LAST_REG=31, FIRST_REG=30, loop=1 -> records 30, 31, then done and a new dump starting at 30 without a further start; regAddr never reads 0.
- start asserted during SEND, and again in the done cycle with loop=0 -> both ignored; busy=0 after done, and only a later start in IDLE begins a dump.
- rst asserted during byte 2 of reg 1 -> txValid=0, busy=0, regAddr=FIRST_REG immediately; a subsequent start produces a full dump from FIRST_REG.
